// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE 16-bit pipeline.
//   - datapath / shift-amount widths
//   - op3 opcode constants and branch condition codes
//   - condition-flag bit indices inside the {S,Z,C,V} flag word
//   - execute-stage FSM state, shifter mode and pending-control types
//   - cond_met(): branch condition evaluation against a flag word
package simple_pkg;

    localparam int WIDTH      = 16;
    localparam int SHAMT_BITS = 4;

    // op3 opcodes
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;
    localparam logic [3:0] OP_IN  = 4'd12;
    localparam logic [3:0] OP_OUT = 4'd13;
    localparam logic [3:0] OP_HLT = 4'd15;

    // branch condition codes
    localparam logic [2:0] CND_EQ = 3'd0;   // Z
    localparam logic [2:0] CND_LT = 3'd1;   // S^V
    localparam logic [2:0] CND_LE = 3'd2;   // Z | (S^V)
    localparam logic [2:0] CND_NE = 3'd3;   // ~Z
    localparam logic [2:0] CND_AL = 3'd4;   // always

    // flag bit indices in {S,Z,C,V}
    localparam int FS = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // Shift mode is the low two bits of the shift opcodes (8..11).
    typedef enum logic [1:0] {SH_SLL, SH_SLR, SH_SRL, SH_SRA} shmode_t;

    // Controls held while an iterative shift is in flight.
    typedef struct packed {
        logic             writereg;
        logic [1:0]       memwrite;
        logic [2:0]       regaddress;
        logic [WIDTH-1:0] address;
        logic [WIDTH-1:0] storedata;
        logic [WIDTH-1:0] target;
    } ctl_t;

    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
        logic lt;
        lt = f[FS] ^ f[FV];
        case (cond)
            CND_EQ:  cond_met = f[FZ];
            CND_LT:  cond_met = lt;
            CND_LE:  cond_met = f[FZ] | lt;
            CND_NE:  cond_met = ~f[FZ];
            CND_AL:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/p3_if.sv
// Decode-to-execute-to-memory bus of the execute stage.
//   upstream (from p2): invalid, alu1, alu2, opcode, writereg, memwrite, regaddress,
//                       address, storedata, isbranch, cond, pc, haltin
//   downstream (to memory stage / control): aluout, writeregout, memwriteout,
//                       regaddressout, addressout, storedataout, flags, branchtaken,
//                       branchtarget, outvalid, busy, haltout
//   modport slave  : the execute stage itself
//   modport master : whatever drives decode-side inputs and consumes results
interface p3_if;
    import simple_pkg::*;

    logic             invalid;
    logic [WIDTH-1:0] alu1;
    logic [WIDTH-1:0] alu2;
    logic [3:0]       opcode;
    logic             writereg;
    logic [1:0]       memwrite;
    logic [2:0]       regaddress;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] storedata;
    logic             isbranch;
    logic [2:0]       cond;
    logic [WIDTH-1:0] pc;
    logic             haltin;

    logic [WIDTH-1:0] aluout;
    logic             writeregout;
    logic [1:0]       memwriteout;
    logic [2:0]       regaddressout;
    logic [WIDTH-1:0] addressout;
    logic [WIDTH-1:0] storedataout;
    logic [3:0]       flags;
    logic             branchtaken;
    logic [WIDTH-1:0] branchtarget;
    logic             outvalid;
    logic             busy;
    logic             haltout;

    modport slave (
        input  invalid, alu1, alu2, opcode, writereg, memwrite, regaddress,
               address, storedata, isbranch, cond, pc, haltin,
        output aluout, writeregout, memwriteout, regaddressout, addressout,
               storedataout, flags, branchtaken, branchtarget, outvalid, busy, haltout
    );

    modport master (
        output invalid, alu1, alu2, opcode, writereg, memwrite, regaddress,
               address, storedata, isbranch, cond, pc, haltin,
        input  aluout, writeregout, memwriteout, regaddressout, addressout,
               storedataout, flags, branchtaken, branchtarget, outvalid, busy, haltout
    );

endinterface

// File: rtl/p3_shifter.sv
// Iterative shifter: one bit position per clock.
//   clockp3  in   stage clock
//   reset    in   asynchronous active-high reset (aborts a shift in progress)
//   load     in   capture din / amount / mode this edge
//   mode     in   SLL / SLR (rotate left) / SRL / SRA
//   din      in   operand to shift
//   amount   in   number of bit positions
//   value    out  current shifted value
//   carry    out  last bit shifted out (0 until the first shift)
//   done     out  no shift steps remain
module p3_shifter
    import simple_pkg::*;
(
    input  logic                  clockp3,
    input  logic                  reset,
    input  logic                  load,
    input  shmode_t               mode,
    input  logic [WIDTH-1:0]      din,
    input  logic [SHAMT_BITS-1:0] amount,
    output logic [WIDTH-1:0]      value,
    output logic                  carry,
    output logic                  done
);

    logic [SHAMT_BITS-1:0] count;
    shmode_t               mode_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clockp3 or posedge reset) begin
        if (reset) begin
            value  <= '0;
            carry  <= 1'b0;
            count  <= '0;
            mode_q <= SH_SLL;
        end else if (load) begin
            value  <= din;
            carry  <= 1'b0;
            count  <= amount;
            mode_q <= mode;
        end else if (count != '0) begin
            count <= count - SHAMT_BITS'(1);
            case (mode_q)
                SH_SLL: begin
                    value <= {value[WIDTH-2:0], 1'b0};
                    carry <= value[WIDTH-1];
                end
                SH_SLR: begin
                    value <= {value[WIDTH-2:0], value[WIDTH-1]};
                    carry <= value[WIDTH-1];
                end
                SH_SRL: begin
                    value <= {1'b0, value[WIDTH-1:1]};
                    carry <= value[0];
                end
                SH_SRA: begin
                    value <= {value[WIDTH-1], value[WIDTH-1:1]};
                    carry <= value[0];
                end
            endcase
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/p3.sv
// Execute stage of the SIMPLE pipeline: ALU, S/Z/C/V flags, branch resolution,
// iterative shifts, and registered hand-off of memory/writeback controls.
//   clockp3  in   stage clock
//   reset    in   asynchronous active-high reset
//   bus      p3_if.slave: decode inputs, registered results/controls, flags,
//            branchtaken/branchtarget, outvalid pulse, busy, sticky haltout
module p3
    import simple_pkg::*;
(
    input  logic clockp3,
    input  logic reset,
    p3_if.slave  bus
);

    state_t                state, state_nxt;
    logic                  accept, load_shift, issue_now, issue_shift, is_shift;
    logic [SHAMT_BITS-1:0] amount;
    logic [WIDTH-1:0]      sh_value;
    logic                  sh_carry, sh_done;
    logic [3:0]            sh_flags;
    ctl_t                  pend;
    logic [WIDTH:0]        sum, diff;
    logic [WIDTH-1:0]      alu_res;
    logic [3:0]            alu_flags;
    logic                  upd_sz;

    // Branches reuse the opcode field, so they never take the shift path.
    assign is_shift = !bus.isbranch && (bus.opcode inside {OP_SLL, OP_SLR, OP_SRL, OP_SRA});
    assign amount   = bus.alu2[SHAMT_BITS-1:0];

    // ---- FSM: state register
    always_ff @(posedge clockp3 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ---- FSM: next state
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (load_shift) state_nxt = ST_SHIFT;
            ST_SHIFT: if (sh_done)    state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs
    // A halted stage accepts nothing until reset.
    always_comb begin
        accept      = (state == ST_IDLE) && bus.invalid && !bus.haltout;
        load_shift  = accept && is_shift && (amount != '0);
        issue_now   = accept && !load_shift;
        issue_shift = (state == ST_SHIFT) && sh_done;
        bus.busy    = (state == ST_SHIFT);
    end

    p3_shifter u_shifter (
        .clockp3 (clockp3),
        .reset   (reset),
        .load    (load_shift),
        .mode    (shmode_t'(bus.opcode[1:0])),
        .din     (bus.alu1),
        .amount  (amount),
        .value   (sh_value),
        .carry   (sh_carry),
        .done    (sh_done)
    );

    // ---- single-cycle ALU and flag update
    always_comb begin
        sum       = {1'b0, bus.alu1} + {1'b0, bus.alu2};
        diff      = {1'b0, bus.alu1} - {1'b0, bus.alu2};
        alu_res   = bus.alu1;
        alu_flags = bus.flags;
        upd_sz    = 1'b1;
        case (bus.opcode)
            OP_ADD: begin
                alu_res       = sum[WIDTH-1:0];
                alu_flags[FC] = sum[WIDTH];
                alu_flags[FV] = (bus.alu1[WIDTH-1] == bus.alu2[WIDTH-1]) &&
                                (sum[WIDTH-1] != bus.alu1[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                // bit WIDTH of the zero-extended difference is the borrow
                alu_res       = diff[WIDTH-1:0];
                alu_flags[FC] = diff[WIDTH];
                alu_flags[FV] = (bus.alu1[WIDTH-1] != bus.alu2[WIDTH-1]) &&
                                (diff[WIDTH-1] != bus.alu1[WIDTH-1]);
            end
            OP_AND: begin alu_res = bus.alu1 & bus.alu2; alu_flags[FC] = 1'b0; alu_flags[FV] = 1'b0; end
            OP_OR:  begin alu_res = bus.alu1 | bus.alu2; alu_flags[FC] = 1'b0; alu_flags[FV] = 1'b0; end
            OP_XOR: begin alu_res = bus.alu1 ^ bus.alu2; alu_flags[FC] = 1'b0; alu_flags[FV] = 1'b0; end
            OP_MOV: alu_res = bus.alu2;
            // Only a zero-amount shift reaches this path: operand passes through.
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                alu_flags[FC] = 1'b0;
                alu_flags[FV] = 1'b0;
            end
            OP_IN, OP_OUT, OP_HLT: upd_sz = 1'b0;
            default:               upd_sz = 1'b0;
        endcase
        if (upd_sz) begin
            alu_flags[FS] = alu_res[WIDTH-1];
            alu_flags[FZ] = (alu_res == '0);
        end
        if (bus.isbranch) begin
            alu_res   = '0;
            alu_flags = bus.flags;
        end
    end

    always_comb begin
        sh_flags     = '0;
        sh_flags[FS] = sh_value[WIDTH-1];
        sh_flags[FZ] = (sh_value == '0);
        sh_flags[FC] = sh_carry;
    end

    // Controls of a multi-cycle shift are held here until its result issues.
    always_ff @(posedge clockp3 or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else if (load_shift) begin
            pend <= '{writereg:   bus.writereg,
                      memwrite:   bus.memwrite,
                      regaddress: bus.regaddress,
                      address:    bus.address,
                      storedata:  bus.storedata,
                      target:     bus.pc + WIDTH'(1) + bus.address};
        end
    end

    // ---- registered stage outputs
    always_ff @(posedge clockp3 or posedge reset) begin
        if (reset) begin
            bus.aluout        <= '0;
            bus.flags         <= '0;
            bus.writeregout   <= 1'b0;
            bus.memwriteout   <= '0;
            bus.regaddressout <= '0;
            bus.addressout    <= '0;
            bus.storedataout  <= '0;
            bus.branchtaken   <= 1'b0;
            bus.branchtarget  <= '0;
            bus.outvalid      <= 1'b0;
            bus.haltout       <= 1'b0;
        end else begin
            bus.outvalid    <= issue_now | issue_shift;
            bus.branchtaken <= 1'b0;
            if (accept && (bus.haltin || bus.opcode == OP_HLT))
                bus.haltout <= 1'b1;
            if (issue_now) begin
                bus.aluout        <= alu_res;
                bus.flags         <= alu_flags;
                bus.writeregout   <= bus.writereg && !(bus.opcode == OP_CMP && !bus.isbranch);
                bus.memwriteout   <= bus.memwrite;
                bus.regaddressout <= bus.regaddress;
                bus.addressout    <= bus.address;
                bus.storedataout  <= bus.storedata;
                // flags here are still those left by the previous instruction
                bus.branchtaken   <= bus.isbranch && cond_met(bus.cond, bus.flags);
                bus.branchtarget  <= bus.pc + WIDTH'(1) + bus.address;
            end else if (issue_shift) begin
                bus.aluout        <= sh_value;
                bus.flags         <= sh_flags;
                bus.writeregout   <= pend.writereg;
                bus.memwriteout   <= pend.memwrite;
                bus.regaddressout <= pend.regaddress;
                bus.addressout    <= pend.address;
                bus.storedataout  <= pend.storedata;
                bus.branchtarget  <= pend.target;
            end
        end
    end

endmodule

// File: tb/tb_p3.sv
// Directed bench for the p3 execute stage: ALU/flag results, branch resolution,
// iterative shift timing, reset abort and sticky halt.
module tb_p3;
    import simple_pkg::*;

    logic clockp3 = 1'b0;
    logic reset   = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    int          lat, busy_cnt, ov_cnt, first_ov;
    logic [15:0] cap_res, cap_sd, cap_ad;
    logic [3:0]  cap_fl;
    logic [1:0]  cap_mw;

    p3_if bus ();

    p3 dut (
        .clockp3 (clockp3),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clockp3 = ~clockp3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.invalid    = 1'b0;
        bus.alu1       = '0;
        bus.alu2       = '0;
        bus.opcode     = OP_ADD;
        bus.writereg   = 1'b0;
        bus.memwrite   = 2'b00;
        bus.regaddress = '0;
        bus.address    = '0;
        bus.storedata  = '0;
        bus.isbranch   = 1'b0;
        bus.cond       = '0;
        bus.pc         = '0;
        bus.haltin     = 1'b0;
    endtask

    // Issue one instruction for one cycle; lat = negedges after the accept
    // edge until outvalid is seen (-1 if it never comes).
    task automatic do_op(input logic [3:0] op, input logic [15:0] a1, input logic [15:0] a2,
                         output int l);
        @(negedge clockp3);
        bus.opcode  = op;
        bus.alu1    = a1;
        bus.alu2    = a2;
        bus.invalid = 1'b1;
        @(negedge clockp3);
        bus.invalid = 1'b0;
        l = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.outvalid) begin
                l = i;
                break;
            end
            @(negedge clockp3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        repeat (2) @(negedge clockp3);
        check("rst_aluout",   bus.aluout, 0);
        check("rst_flags",    bus.flags, 0);
        check("rst_outvalid", bus.outvalid, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_haltout",  bus.haltout, 0);
        check("rst_branch",   bus.branchtaken, 0);
        reset = 1'b0;

        // 1: ADD signed overflow
        bus.writereg   = 1'b1;
        bus.regaddress = 3'd5;
        do_op(OP_ADD, 16'h7FFF, 16'h0001, lat);
        check("add_lat",   lat, 0);
        check("add_res",   bus.aluout, 16'h8000);
        check("add_flags", bus.flags, 4'b1001);
        check("add_wr",    bus.writeregout, 1);
        check("add_ra",    bus.regaddressout, 5);
        @(negedge clockp3);
        check("add_pulse", bus.outvalid, 0);

        do_op(OP_SUB, 16'h0000, 16'h0001, lat);
        check("sub_res",   bus.aluout, 16'hFFFF);
        check("sub_flags", bus.flags, 4'b1010);
        do_op(OP_ADD, 16'hFFFF, 16'h0001, lat);
        check("addc_res",   bus.aluout, 16'h0000);
        check("addc_flags", bus.flags, 4'b0110);

        // 2: CMP then branch on Z
        do_op(OP_CMP, 16'h0005, 16'h0005, lat);
        check("cmp_flags", bus.flags, 4'b0100);
        check("cmp_wr",    bus.writeregout, 0);
        bus.isbranch = 1'b1;
        bus.cond     = CND_EQ;
        bus.address  = 16'h0003;
        bus.pc       = 16'h0010;
        do_op(OP_ADD, 16'h0001, 16'h0001, lat);
        check("br_taken",  bus.branchtaken, 1);
        check("br_target", bus.branchtarget, 16'h0014);
        check("br_res",    bus.aluout, 0);
        check("br_flags",  bus.flags, 4'b0100);
        @(negedge clockp3);
        check("br_pulse",  bus.branchtaken, 0);
        bus.cond = CND_NE;
        do_op(OP_ADD, 16'h0001, 16'h0001, lat);
        check("bne_taken", bus.branchtaken, 0);
        idle_inputs();

        // 3: SRA by 2 with invalid pulses while busy
        bus.writereg   = 1'b1;
        bus.regaddress = 3'd2;
        bus.memwrite   = 2'b10;
        bus.storedata  = 16'hBEEF;
        bus.address    = 16'h0042;
        @(negedge clockp3);
        bus.opcode  = OP_SRA;
        bus.alu1    = 16'h8004;
        bus.alu2    = 16'h0002;
        bus.invalid = 1'b1;
        @(negedge clockp3);
        busy_cnt = 0;
        ov_cnt   = 0;
        first_ov = -1;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.outvalid) begin
                ov_cnt++;
                if (first_ov < 0) begin
                    first_ov = i;
                    cap_res  = bus.aluout;
                    cap_fl   = bus.flags;
                    cap_mw   = bus.memwriteout;
                    cap_sd   = bus.storedataout;
                    cap_ad   = bus.addressout;
                end
            end
            bus.opcode    = OP_ADD;
            bus.alu1      = 16'h0001;
            bus.alu2      = 16'h0001;
            bus.memwrite  = 2'b00;
            bus.storedata = '0;
            bus.address   = '0;
            bus.invalid   = (i < 3);
            @(negedge clockp3);
        end
        check("sra_busy",  busy_cnt, 3);
        check("sra_ovcnt", ov_cnt, 1);
        check("sra_lat",   first_ov, 3);
        check("sra_res",   cap_res, 16'hE001);
        check("sra_flags", cap_fl, 4'b1000);
        check("sra_mw",    cap_mw, 2'b10);
        check("sra_sd",    cap_sd, 16'hBEEF);
        check("sra_ad",    cap_ad, 16'h0042);
        idle_inputs();

        // 4: rotate left by 1, then zero-amount shift
        do_op(OP_SLR, 16'h8001, 16'h0001, lat);
        check("slr_lat",   lat, 2);
        check("slr_res",   bus.aluout, 16'h0003);
        check("slr_flags", bus.flags, 4'b0010);
        do_op(OP_SLL, 16'h1234, 16'h0010, lat);
        check("sll0_lat",   lat, 0);
        check("sll0_res",   bus.aluout, 16'h1234);
        check("sll0_flags", bus.flags, 4'b0000);

        // 5: reset in the middle of a shift
        @(negedge clockp3);
        bus.opcode  = OP_SRL;
        bus.alu1    = 16'hFFFF;
        bus.alu2    = 16'h000F;
        bus.invalid = 1'b1;
        @(negedge clockp3);
        bus.invalid = 1'b0;
        repeat (3) @(negedge clockp3);
        check("mid_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("abort_res",  bus.aluout, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ov",   bus.outvalid, 0);
        @(negedge clockp3);
        reset  = 1'b0;
        ov_cnt = 0;
        repeat (20) begin
            @(negedge clockp3);
            if (bus.outvalid) ov_cnt++;
        end
        check("abort_noissue", ov_cnt, 0);
        do_op(OP_ADD, 16'h0001, 16'h0001, lat);
        check("post_lat", lat, 0);
        check("post_res", bus.aluout, 16'h0002);

        // 6: halt is sticky and blocks further instructions
        do_op(OP_HLT, 16'h0000, 16'h0000, lat);
        check("hlt_halt", bus.haltout, 1);
        @(negedge clockp3);
        bus.opcode  = OP_ADD;
        bus.alu1    = 16'h0003;
        bus.alu2    = 16'h0004;
        bus.invalid = 1'b1;
        ov_cnt = 0;
        repeat (10) begin
            @(negedge clockp3);
            if (bus.outvalid) ov_cnt++;
        end
        bus.invalid = 1'b0;
        check("hlt_blocked", ov_cnt, 0);
        check("hlt_sticky",  bus.haltout, 1);
        reset = 1'b1;
        #1;
        check("hlt_cleared", bus.haltout, 0);
        @(negedge clockp3);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
